silencer_core: RTL and testbench

Parametrised, time-multiplexed silencer for the transducer output path. It replaces the separate step-calculation and interpolation stages with one pipelined datapath. Each input sample carries an intensity and phase target for one channel. The block moves a per-channel state toward that target by at most a programmable rate per frame, and takes the shortest path around the phase circle. It sits between the modulation/STM sample source and the PWM generator, and adds a per-frame "settled" indication.

---
 rtl/silencer_core.sv | 197 +++++++++++++++++++
 tb/tb_silencer_core.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silencer_core.sv
// Time-multiplexed silencer: per-channel intensity/phase state slews toward each target by a per-frame rate.
// Optional SILENCER_BYPASS_EN adds a bypass input that snaps state straight to target.
module silencer_core #(
    parameter int DEPTH           = 249,
    parameter int INTENSITY_WIDTH = 16,
    parameter int PHASE_WIDTH     = 8,
    parameter int RATE_WIDTH      = 16,
    localparam int CH_W           = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef SILENCER_BYPASS_EN
    input  logic                       bypass,
`endif
    input  logic                       din_valid,
    input  logic [INTENSITY_WIDTH-1:0] intensity_in,
    input  logic [PHASE_WIDTH-1:0]     phase_in,
    input  logic [RATE_WIDTH-1:0]      update_rate_intensity,
    input  logic [RATE_WIDTH-1:0]      update_rate_phase,
    output logic                       ready,
    output logic [INTENSITY_WIDTH-1:0] intensity_out,
    output logic [PHASE_WIDTH-1:0]     phase_out,
    output logic                       dout_valid,
    output logic [CH_W-1:0]            dout_ch,
    output logic                       settled
);

    localparam int IW = INTENSITY_WIDTH;
    localparam int PW = PHASE_WIDTH;
    localparam int RW = RATE_WIDTH;
    localparam int SW = PW + 8;
    localparam int XW = ((IW > RW) ? IW : RW) + 1;
    localparam int YW = ((SW > RW) ? SW : RW) + 1;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(DEPTH - 1);
    localparam logic [SW-1:0]   OPPOSITE = {1'b1, {(SW-1){1'b0}}};

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_reg;
    logic [CH_W-1:0]   init_cnt_reg;
    logic [CH_W-1:0]   ch_cnt_reg;
    logic [RW-1:0]     rate_i_reg;
    logic [RW-1:0]     rate_p_reg;
    logic              bypass_reg;
    logic              acc_reg;

    logic [IW-1:0]     int_mem [DEPTH];
    logic [SW-1:0]     ph_mem  [DEPTH];
    logic [IW-1:0]     int_rd_reg;
    logic [SW-1:0]     ph_rd_reg;

    logic              s0_valid_reg;
    logic [CH_W-1:0]   s0_ch_reg;
    logic [IW-1:0]     s0_int_t_reg;
    logic [PW-1:0]     s0_ph_t_reg;

    logic              accept;
    logic [IW-1:0]     int_next;
    logic [SW-1:0]     ph_next;
    logic              match;

    logic              wr_en;
    logic [CH_W-1:0]   wr_addr;
    logic [IW-1:0]     wr_int;
    logic [SW-1:0]     wr_ph;

`ifndef SILENCER_BYPASS_EN
    assign bypass_reg = 1'b0;
`endif

    assign accept = (state_reg == RUN) && din_valid;

    // Intensity slew: compare the gap against the rate so no sum can overflow.
    logic [XW-1:0] c_x, t_x, r_x;
    always_comb begin
        c_x      = XW'(int_rd_reg);
        t_x      = XW'(s0_int_t_reg);
        r_x      = XW'(rate_i_reg);
        int_next = int_rd_reg;
        if (bypass_reg) begin
            int_next = s0_int_t_reg;
        end else if (t_x > c_x) begin
            int_next = (t_x - c_x <= r_x) ? s0_int_t_reg : IW'(c_x + r_x);
        end else if (t_x < c_x) begin
            int_next = (c_x - t_x <= r_x) ? s0_int_t_reg : IW'(c_x - r_x);
        end
    end

    // Phase slew along the shorter arc; the exact opposite point goes the + way.
    logic [SW-1:0] ph_t, ph_d, ph_mag;
    logic          ph_plus;
    always_comb begin
        ph_t    = {s0_ph_t_reg, 8'd0};
        ph_d    = ph_t - ph_rd_reg;
        ph_mag  = ph_d[SW-1] ? (SW'(0) - ph_d) : ph_d;
        ph_plus = !ph_d[SW-1] || (ph_d == OPPOSITE);
        ph_next = ph_rd_reg;
        if (bypass_reg || (YW'(ph_mag) <= YW'(rate_p_reg))) begin
            ph_next = ph_t;
        end else if (ph_plus) begin
            ph_next = ph_rd_reg + SW'(rate_p_reg);
        end else begin
            ph_next = ph_rd_reg - SW'(rate_p_reg);
        end
        match = (int_next == s0_int_t_reg) && (ph_next == ph_t);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s0_ch_reg;
        wr_int  = int_next;
        wr_ph   = ph_next;
        if (state_reg == INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt_reg;
            wr_int  = '0;
            wr_ph   = '0;
        end else if (s0_valid_reg) begin
            wr_en = 1'b1;
        end
    end

    // State memory: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            int_mem[wr_addr] <= wr_int;
            ph_mem[wr_addr]  <= wr_ph;
        end
        int_rd_reg <= int_mem[ch_cnt_reg];
        ph_rd_reg  <= ph_mem[ch_cnt_reg];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= INIT;
            init_cnt_reg  <= '0;
            ch_cnt_reg    <= '0;
            rate_i_reg    <= '0;
            rate_p_reg    <= '0;
`ifdef SILENCER_BYPASS_EN
            bypass_reg    <= 1'b0;
`endif
            acc_reg       <= 1'b0;
            s0_valid_reg  <= 1'b0;
            s0_ch_reg     <= '0;
            s0_int_t_reg  <= '0;
            s0_ph_t_reg   <= '0;
            ready         <= 1'b0;
            intensity_out <= '0;
            phase_out     <= '0;
            dout_valid    <= 1'b0;
            dout_ch       <= '0;
            settled       <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    init_cnt_reg <= init_cnt_reg + 1'b1;
                    if (init_cnt_reg == LAST_CH) begin
                        state_reg <= RUN;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        ch_cnt_reg <= (ch_cnt_reg == LAST_CH) ? '0 : ch_cnt_reg + 1'b1;
                        // Rates are frame-wide: only channel 0 samples them.
                        if (ch_cnt_reg == '0) begin
                            rate_i_reg <= update_rate_intensity;
                            rate_p_reg <= update_rate_phase;
`ifdef SILENCER_BYPASS_EN
                            bypass_reg <= bypass;
`endif
                        end
                    end
                end
            endcase

            s0_valid_reg <= accept;
            if (accept) begin
                s0_ch_reg    <= ch_cnt_reg;
                s0_int_t_reg <= intensity_in;
                s0_ph_t_reg  <= phase_in;
            end

            dout_valid <= s0_valid_reg;
            settled    <= 1'b0;
            if (s0_valid_reg) begin
                intensity_out <= int_next;
                phase_out     <= ph_next[SW-1:8];
                dout_ch       <= s0_ch_reg;
                acc_reg       <= (s0_ch_reg == '0) ? match : (acc_reg && match);
                settled       <= (s0_ch_reg == LAST_CH) && acc_reg && match;
            end
        end
    end

endmodule

// File: tb/tb_silencer_core.sv
// Randomised bench for silencer_core against an arithmetic per-channel model of the slew rules.
`timescale 1ns/1ps
module tb_silencer_core;

    localparam int DEPTH = 249;
    localparam int IW    = 16;
    localparam int PW    = 8;
    localparam int RW    = 16;
    localparam int SW    = PW + 8;
    localparam int CW    = $clog2(DEPTH);
    localparam int M     = 1 << SW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din_valid = 1'b0;
    logic [IW-1:0] intensity_in = '0;
    logic [PW-1:0] phase_in = '0;
    logic [RW-1:0] rate_i = '0;
    logic [RW-1:0] rate_p = '0;
`ifdef SILENCER_BYPASS_EN
    logic          bypass = 1'b0;
`endif
    logic          ready;
    logic [IW-1:0] intensity_out;
    logic [PW-1:0] phase_out;
    logic          dout_valid;
    logic [CW-1:0] dout_ch;
    logic          settled;

    always #5 clk = ~clk;

    silencer_core #(.DEPTH(DEPTH), .INTENSITY_WIDTH(IW), .PHASE_WIDTH(PW), .RATE_WIDTH(RW)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SILENCER_BYPASS_EN
        .bypass(bypass),
`endif
        .din_valid(din_valid),
        .intensity_in(intensity_in),
        .phase_in(phase_in),
        .update_rate_intensity(rate_i),
        .update_rate_phase(rate_p),
        .ready(ready),
        .intensity_out(intensity_out),
        .phase_out(phase_out),
        .dout_valid(dout_valid),
        .dout_ch(dout_ch),
        .settled(settled)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int ch;
        int iv;
        int pv;
        bit st;
    } exp_t;

    exp_t q[$];
    int   m_int [DEPTH];
    int   m_ph  [DEPTH];
    int   init_cnt = 0;
    int   m_ch = 0;
    int   m_rate_i = 0;
    int   m_rate_p = 0;
    bit   m_byp = 0;
    bit   frame_ok = 0;
    int   cyc = 0;

    always @(posedge clk) begin : model
        int T, C, R, t, c, d, ad;
        bit ok;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            init_cnt = 0;
            m_ch     = 0;
            m_rate_i = 0;
            m_rate_p = 0;
            m_byp    = 0;
            frame_ok = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_int[i] = 0;
                m_ph[i]  = 0;
            end
        end else if (init_cnt < DEPTH) begin
            init_cnt++;
        end else if (din_valid) begin
            if (m_ch == 0) begin
                m_rate_i = int'(rate_i);
                m_rate_p = int'(rate_p);
`ifdef SILENCER_BYPASS_EN
                m_byp = bypass;
`endif
            end
            T = int'(intensity_in);
            C = m_int[m_ch];
            R = m_rate_i;
            if (m_byp)       C = T;
            else if (T > C)  C = (C + R > T) ? T : C + R;
            else if (T < C)  C = (C - R < T) ? T : C - R;
            t = int'(phase_in) * 256;
            c = m_ph[m_ch];
            R = m_rate_p;
            d = ((t - c) % M + M) % M;
            if (d >= M / 2) d = d - M;
            ad = (d < 0) ? -d : d;
            if (m_byp || ad <= R)              c = t;
            else if (d > 0 || d == -(M / 2))   c = (c + R) % M;
            else                               c = (c - R + M) % M;
            m_int[m_ch] = C;
            m_ph[m_ch]  = c;
            ok = (C == T) && (c == t);
            frame_ok = (m_ch == 0) ? ok : (frame_ok && ok);
            e.due = cyc + 1;
            e.ch  = m_ch;
            e.iv  = C;
            e.pv  = c / 256;
            e.st  = (m_ch == DEPTH - 1) && frame_ok;
            q.push_back(e);
            m_ch = (m_ch + 1) % DEPTH;
        end
    end

    // ---------------- compare ----------------
    int last_int [DEPTH];
    int last_ph  [DEPTH];
    int ch5_i[$];
    int ch5_p[$];
    int frames_out = 0;
    int first_settled = 0;
    bit capture_first = 0;
    int first_ch = -1;
    int first_int = -1;
    int first_ph = -1;

    always @(negedge clk) begin : compare
        exp_t e;
        if (!rst_n) begin
            q.delete();
            chk("reset_outputs", {ready, dout_valid, settled, dout_ch, intensity_out, phase_out}, 0);
        end else begin
            chk("ready", ready, (init_cnt >= DEPTH));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("dout_valid", dout_valid, 1);
                chk("dout_ch", dout_ch, e.ch);
                chk("intensity_out", intensity_out, e.iv);
                chk("phase_out", phase_out, e.pv);
                chk("settled", settled, e.st);
                last_int[dout_ch] = int'(intensity_out);
                last_ph[dout_ch]  = int'(phase_out);
                if (dout_ch == 5) begin
                    ch5_i.push_back(int'(intensity_out));
                    ch5_p.push_back(int'(phase_out));
                end
                if (dout_ch == CW'(DEPTH - 1)) begin
                    frames_out++;
                    if (settled && first_settled == 0) first_settled = frames_out;
                end
                if (capture_first) begin
                    capture_first = 0;
                    first_ch  = int'(dout_ch);
                    first_int = int'(intensity_out);
                    first_ph  = int'(phase_out);
                end
            end else begin
                chk("idle_outputs", {dout_valid, settled}, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit rnd, input int ti, input int tp, input int gap_pct,
                             input int chg_ch, input int new_ri, input int new_rp);
        for (int ch = 0; ch < DEPTH; ch++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                din_valid = 1'b0;
                tick();
            end
            if (ch == chg_ch) begin
                rate_i = RW'(new_ri);
                rate_p = RW'(new_rp);
            end
            din_valid    = 1'b1;
            intensity_in = rnd ? IW'($urandom) : IW'(ti);
            phase_in     = rnd ? PW'($urandom) : PW'(tp);
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        din_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n  = 1'b1;
        rate_i = 16'hFFFF;
        for (int i = 0; i < DEPTH; i++) begin
            din_valid    = 1'b1;
            intensity_in = IW'($urandom);
            phase_in     = PW'($urandom);
            tick();
            if (i == DEPTH - 2) chk("ready_before_init_done", ready, 0);
            if (i == DEPTH - 1) chk("ready_after_init", ready, 1);
        end
        drain();

        // Intensity ramp toward 0x1000 at 0x100 per frame.
        rate_i = 16'h0100;
        rate_p = 16'h0000;
        ch5_i.delete();
        frames_out = 0;
        first_settled = 0;
        for (int f = 0; f < 17; f++) run_frame(0, 16'h1000, 0, 0, -1, 0, 0);
        drain();
        chk("ramp_ch5_count", ch5_i.size(), 17);
        if (ch5_i.size() == 17) begin
            for (int f = 1; f <= 16; f++) chk("ramp_ch5_value", ch5_i[f-1], 16'h0100 * f);
            chk("ramp_ch5_hold", ch5_i[16], 16'h1000);
        end
        chk("ramp_first_settled_frame", first_settled, 16);
        chk("ramp_model_ch5", m_int[5], 16'h1000);

        // Phase wrap through zero.
        rate_p = 16'h1000;
        run_frame(0, 16'h1000, 8'h10, 20, -1, 0, 0);
        rate_p = 16'h0800;
        ch5_p.delete();
        for (int f = 0; f < 4; f++) run_frame(0, 16'h1000, 8'hF0, 20, -1, 0, 0);
        drain();
        chk("wrap_ch5_count", ch5_p.size(), 4);
        if (ch5_p.size() == 4) begin
            chk("wrap_ch5_f1", ch5_p[0], 8'h08);
            chk("wrap_ch5_f2", ch5_p[1], 8'h00);
            chk("wrap_ch5_f3", ch5_p[2], 8'hF8);
            chk("wrap_ch5_f4", ch5_p[3], 8'hF0);
        end
        chk("wrap_model_ch5", m_ph[5], 16'hF000);

        // Exact opposite point moves in the + direction.
        rate_p = 16'h1000;
        run_frame(0, 16'h1000, 8'h00, 0, -1, 0, 0);
        rate_p = 16'h4000;
        run_frame(0, 16'h1000, 8'h80, 0, -1, 0, 0);
        drain();
        chk("opposite_ch5", last_ph[5], 8'h40);
        chk("opposite_model_ch5", m_ph[5], 16'h4000);

        // Rate change at channel 100 applies only from the next frame.
        rate_i = 16'h0010;
        rate_p = 16'h0000;
        run_frame(0, 0, 8'h40, 10, 100, 16'h0020, 0);
        drain();
        chk("midrate_ch50", last_int[50], 16'h0FF0);
        chk("midrate_ch200", last_int[200], 16'h0FF0);
        run_frame(0, 0, 8'h40, 10, -1, 0, 0);
        drain();
        chk("midrate_next_ch200", last_int[200], 16'h0FD0);

        // Full-scale rate settles any target in one frame; zero rate holds.
        rate_i = 16'hFFFF;
        rate_p = 16'hFFFF;
        frames_out = 0;
        first_settled = 0;
        run_frame(1, 0, 0, 15, -1, 0, 0);
        drain();
        chk("fullrate_settled_frame", first_settled, 1);
        rate_i = 16'h0000;
        rate_p = 16'h0000;
        run_frame(1, 0, 0, 15, -1, 0, 0);

        // Randomised frames with gaps and mid-frame rate changes.
        for (int f = 0; f < 6; f++) begin
            rate_i = RW'($urandom_range(0, 16'h3000));
            rate_p = RW'($urandom);
            run_frame(1, 0, 0, 25, $urandom_range(0, DEPTH - 1), $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
        end
        drain();

`ifdef SILENCER_BYPASS_EN
        rate_i = 16'h0001;
        rate_p = 16'h0001;
        bypass = 1'b1;
        frames_out = 0;
        first_settled = 0;
        run_frame(0, 16'hFFFF, 8'h7F, 0, -1, 0, 0);
        bypass = 1'b0;
        drain();
        chk("bypass_int_ch5", last_int[5], 16'hFFFF);
        chk("bypass_ph_ch5", last_ph[5], 8'h7F);
        chk("bypass_settled", first_settled, 1);
`endif

        // Reset in the middle of a frame, right after channel 120.
        rate_i = 16'h0010;
        for (int ch = 0; ch <= 120; ch++) begin
            din_valid    = 1'b1;
            intensity_in = IW'($urandom);
            phase_in     = PW'($urandom);
            tick();
        end
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_dout_valid", dout_valid, 0);
        chk("midreset_intensity", intensity_out, 0);
        chk("midreset_ready", ready, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (DEPTH + 2) tick();
        capture_first = 1;
        rate_i = 16'h0010;
        rate_p = 16'h0100;
        run_frame(0, 16'h0050, 8'h03, 0, -1, 0, 0);
        drain();
        chk("postreset_first_ch", first_ch, 0);
        chk("postreset_first_int", first_int, 16'h0010);
        chk("postreset_first_ph", first_ph, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
